// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter.
// Command fields are sized to the shared RAM; the top's width parameters default to these.
package ram_arb_pkg;

  localparam int unsigned RamDataWidth = 8;
  localparam int unsigned RamAddrWidth = 3;
  localparam int unsigned MaxIdWidth   = 3;  // covers up to 8 requesters

  typedef struct packed {
    logic                    we;
    logic [RamAddrWidth-1:0] addr;
    logic [RamDataWidth-1:0] data;
  } ram_cmd_t;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
  } rd_tag_t;

  function automatic int unsigned id_width(int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set bit of elig_i searching upward from ptr_i with wrap-around.
// Purely combinational; the pointer register lives in the caller.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned PtrWidth = id_width(NumReq)
) (
  input  logic [NumReq-1:0]   elig_i,
  input  logic [PtrWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   grant_o
);

  logic                found;
  logic [PtrWidth-1:0] idx;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      idx = PtrWidth'((32'(ptr_i) + off) % NumReq);
      if (!found && elig_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between NUM_REQ requesters: round-robin grant, registered command,
// read-tag pipeline for response routing, and a read-after-write hazard window.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_WIDTH    = RamDataWidth,
  parameter int unsigned ADDRESS_WIDTH = RamAddrWidth,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_din,
  input  logic [DATA_WIDTH-1:0]            ram_dout,
  output logic                             busy
);

  localparam int unsigned ID_WIDTH = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]       rd_hit, elig, grant;
  logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic                     transfer;
  ram_cmd_t                 win_cmd, cmd_q;
  logic [MaxIdWidth-1:0]    win_id, cmd_id_q;
  logic                     en_q;
  rd_tag_t                  tag_q [READ_LATENCY];
  logic                     tag_any;
  logic [WRITE_LATENCY-1:0] haz_vld_q;
  logic [ADDRESS_WIDTH-1:0] haz_addr_q [WRITE_LATENCY];

  // The write being granted this cycle needs no entry: only one grant happens per cycle,
  // so a same-address read cannot slip past it. Stored entries cover the following cycles.
  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < WRITE_LATENCY; k++) begin
        if (haz_vld_q[k] && (haz_addr_q[k] == req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
          rd_hit[i] = 1'b1;
        end
      end
    end
  end

  assign elig = req_valid & (req_we | ~rd_hit);

  rr_arbiter #(
    .NumReq   (NUM_REQ),
    .PtrWidth (ID_WIDTH)
  ) u_rr_arbiter (
    .elig_i  (elig),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  // Nothing may hand over while reset is held, even with requests pending.
  assign req_ready = rst_n ? grant : '0;
  assign transfer  = |req_ready;

  always_comb begin
    win_cmd = '0;
    win_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        win_cmd.we   = req_we[i];
        win_cmd.addr = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        win_cmd.data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        win_id       = MaxIdWidth'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = ID_WIDTH'((32'(win_id) + 32'd1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      en_q     <= 1'b0;
      cmd_q    <= '0;
      cmd_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      en_q     <= transfer;
      if (transfer) begin
        cmd_q    <= win_cmd;
        cmd_id_q <= win_id;
      end else begin
        cmd_q.we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0].valid <= en_q & ~cmd_q.we;
      tag_q[0].id    <= cmd_id_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haz_vld_q <= '0;
      for (int k = 0; k < WRITE_LATENCY; k++) begin
        haz_addr_q[k] <= '0;
      end
    end else begin
      haz_vld_q[0]  <= transfer & win_cmd.we;
      haz_addr_q[0] <= win_cmd.addr;
      for (int k = 1; k < WRITE_LATENCY; k++) begin
        haz_vld_q[k]  <= haz_vld_q[k-1];
        haz_addr_q[k] <= haz_addr_q[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[READ_LATENCY-1].valid &&
                     (tag_q[READ_LATENCY-1].id == MaxIdWidth'(i));
    end
    rsp_rdata = (|rsp_valid) ? ram_dout : '0;
  end

  always_comb begin
    tag_any = 1'b0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      tag_any = tag_any | tag_q[k].valid;
    end
  end

  assign busy     = en_q | tag_any | (|haz_vld_q);
  assign ram_en   = en_q;
  assign ram_we   = cmd_q.we;
  assign ram_addr = cmd_q.addr;
  assign ram_din  = cmd_q.data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural latency RAM on the port
// (read latency 3, write latency 3).
module tb_ram_port_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Dw   = 8;
  localparam int unsigned Aw   = 3;
  localparam int unsigned Rl   = 3;
  localparam int unsigned Wl   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NReq-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NReq*Aw-1:0] req_addr;
  logic [NReq*Dw-1:0] req_wdata;
  logic [Dw-1:0]     rsp_rdata, ram_din, ram_dout;
  logic              ram_en, ram_we, busy;
  logic [Aw-1:0]     ram_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ       (NReq),
    .DATA_WIDTH    (Dw),
    .ADDRESS_WIDTH (Aw),
    .READ_LATENCY  (Rl),
    .WRITE_LATENCY (Wl)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .busy      (busy)
  );

  // Latency RAM: reads sample at the command edge, writes land Wl edges later.
  logic          mem_load;
  logic [Dw-1:0] mem     [8];
  logic [Dw-1:0] rd_pipe [Rl];
  logic          wr_v    [Wl];
  logic [Aw-1:0] wr_a    [Wl];
  logic [Dw-1:0] wr_d    [Wl];

  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram_addr];
    for (int k = 1; k < Rl; k++) rd_pipe[k] <= rd_pipe[k-1];
    wr_v[0] <= ram_en & ram_we;
    wr_a[0] <= ram_addr;
    wr_d[0] <= ram_din;
    for (int k = 1; k < Wl; k++) begin
      wr_v[k] <= wr_v[k-1];
      wr_a[k] <= wr_a[k-1];
      wr_d[k] <= wr_d[k-1];
    end
    if (wr_v[Wl-1]) mem[wr_a[Wl-1]] <= wr_d[Wl-1];
    if (mem_load) begin
      for (int a = 0; a < 8; a++) mem[a] <= 8'(8'h10 + a);
    end
  end

  assign ram_dout = rd_pipe[Rl-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [Aw-1:0] a,
                         input logic [Dw-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*Aw +: Aw]  = a;
    req_wdata[i*Dw +: Dw] = d;
  endtask

  task automatic all_reads();
    for (int i = 0; i < NReq; i++) set_req(i, 1'b1, 1'b0, 3'(i), 8'h00);
  endtask

  task automatic drop_all();
    req_valid = '0;
    req_we    = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_load  = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    all_reads();

    // Reset held with every requester asking.
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check_eq("rst_ram_en", 32'(ram_en), 32'h0);
    check_eq("rst_ram_we", 32'(ram_we), 32'h0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    // Release and run continuous reads: rotation 0,1,2,3 and responses 4 cycles later.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_eq("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k == 1) begin
        check_eq("first_ram_en", 32'(ram_en), 32'h1);
        check_eq("first_ram_addr", 32'(ram_addr), 32'h0);
      end
      if (k >= 4) begin
        check_eq("fair_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((k - 4) % 4)));
        check_eq("fair_rsp_rdata", 32'(rsp_rdata), 32'(8'h10 + (k - 4) % 4));
      end else begin
        check_eq("fair_rsp_early", 32'(rsp_valid), 32'h0);
      end
    end
    @(negedge clk);
    drop_all();
    repeat (6) @(negedge clk);
    #1;
    check_eq("drain_busy", 32'(busy), 32'h0);

    // req2 writes 0xA5 to addr 5, later req1 reads it back.
    @(negedge clk);
    set_req(2, 1'b1, 1'b1, 3'd5, 8'hA5);
    #1;
    check_eq("wr_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check_eq("wr_ram_en", 32'(ram_en), 32'h1);
    check_eq("wr_ram_we", 32'(ram_we), 32'h1);
    check_eq("wr_ram_addr", 32'(ram_addr), 32'h5);
    check_eq("wr_ram_din", 32'(ram_din), 32'hA5);
    check_eq("wr_busy", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    set_req(1, 1'b1, 1'b0, 3'd5, 8'h00);
    #1;
    check_eq("rd_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rd_rsp_not_yet", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    check_eq("rd_rsp_rdata", 32'(rsp_rdata), 32'hA5);

    // Bring the pointer back to 0 through a req3 read.
    @(negedge clk);
    set_req(3, 1'b1, 1'b0, 3'd4, 8'h00);
    #1;
    check_eq("ptr_fix_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    drop_all();
    repeat (5) @(negedge clk);

    // Hazard: req0 writes addr 2 while req1 reads addr 2 and req3 reads addr 6.
    set_req(0, 1'b1, 1'b1, 3'd2, 8'h3C);
    set_req(1, 1'b1, 1'b0, 3'd2, 8'h00);
    set_req(3, 1'b1, 1'b0, 3'd6, 8'h00);
    #1;
    check_eq("haz_t0_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check_eq("haz_t1_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    set_req(3, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check_eq("haz_t2_blocked", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check_eq("haz_t3_blocked", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1;
    check_eq("haz_t4_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check_eq("haz_rsp3_valid", 32'(rsp_valid), 32'h8);
    check_eq("haz_rsp3_rdata", 32'(rsp_rdata), 32'h16);
    repeat (3) @(negedge clk);
    #1;
    check_eq("haz_rsp1_valid", 32'(rsp_valid), 32'h2);
    check_eq("haz_rsp1_rdata", 32'(rsp_rdata), 32'h3C);
    repeat (4) @(negedge clk);

    // Reset with reads in flight.
    all_reads();
    #1;
    check_eq("mid_first_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    @(negedge clk);
    drop_all();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 32'(busy), 32'h0);
    check_eq("mid_rst_ram_en", 32'(ram_en), 32'h0);
    check_eq("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    #1;
    check_eq("mid_rst_rsp_hold", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    all_reads();
    rst_n = 1'b1;
    #1;
    check_eq("mid_ptr_restart", 32'(req_ready), 32'h1);
    check_eq("mid_no_rsp_a", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    drop_all();
    #1;
    check_eq("mid_ram_en", 32'(ram_en), 32'h1);
    check_eq("mid_no_rsp_b", 32'(rsp_valid), 32'h0);
    repeat (6) @(negedge clk);

    // req1 valid on alternate cycles only.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 3'd3, 8'h00);
      #1;
      check_eq("gap_grant", 32'(req_ready), 32'h2);
      if (k > 0) check_eq("gap_en_after_idle", 32'(ram_en), 32'h0);
      @(negedge clk);
      set_req(1, 1'b0, 1'b0, 3'd0, 8'h00);
      #1;
      check_eq("gap_idle_ready", 32'(req_ready), 32'h0);
      check_eq("gap_ram_en", 32'(ram_en), 32'h1);
      check_eq("gap_ram_addr", 32'(ram_addr), 32'h3);
    end
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 3'd0, 8'h00);
    set_req(2, 1'b1, 1'b0, 3'd2, 8'h00);
    set_req(3, 1'b1, 1'b0, 3'd3, 8'h00);
    #1;
    check_eq("gap_ptr_held", 32'(req_ready), 32'h4);
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 3'd0, 8'h00);
    #1;
    check_eq("gap_ptr_next", 32'(req_ready), 32'h8);
    @(negedge clk);
    drop_all();
    repeat (6) @(negedge clk);
    #1;
    check_eq("end_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
